// File: rtl/if_fetch_queue.sv
// Instruction prefetch queue feeding the registered IF/ID stage; flushes drop all wrong-path state.
// Build option: define IFQ_BYPASS_EN to let a fetch arriving at an empty, advancing queue go straight to ID.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int IW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_jump_i,
  input  logic          flush_int_i,
  input  logic [5:0]    stall_i,
  input  logic          fetch_valid_i,
  input  logic [AW-1:0] fetch_pc_i,
  input  logic [IW-1:0] fetch_inst_i,
  output logic          stall_req_o,
  output logic          id_valid_o,
  output logic [AW-1:0] id_pc_o,
  output logic [IW-1:0] id_inst_o,
  output logic          ovf_o
);

  localparam int          PW   = $clog2(DEPTH);
  localparam int          CW   = PW + 1;
  localparam logic        STOP = 1'b1;
  localparam logic [IW-1:0] NOP = IW'(32'h0000_0013);

  logic [AW-1:0] pc_mem   [DEPTH];
  logic [IW-1:0] inst_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;

  logic flush, adv, have, full;
  logic push, pop, load_head, load_fetch, clear_id, ovf_nxt;
  logic unused_stall;

  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  assign flush = flush_jump_i | flush_int_i;
  assign adv   = (stall_i[1] != STOP);
  assign have  = (count != '0);
  assign full  = (count == CW'(DEPTH));

  // One slot of headroom covers the fetch already in flight when pc_reg freezes.
  assign stall_req_o = (count >= CW'(DEPTH - 1));

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    load_head  = 1'b0;
    load_fetch = 1'b0;
    clear_id   = 1'b0;
    ovf_nxt    = 1'b0;
    if (!flush) begin
      if (!adv) begin
        if (fetch_valid_i) begin
          if (!full) push = 1'b1;
          else       ovf_nxt = 1'b1;
        end
      end else if (have) begin
        // The pop frees the head slot, so a same-cycle fetch always fits.
        pop       = 1'b1;
        load_head = 1'b1;
        push      = fetch_valid_i;
      end else if (fetch_valid_i) begin
`ifdef IFQ_BYPASS_EN
        load_fetch = 1'b1;
`else
        push     = 1'b1;
        clear_id = 1'b1;
`endif
      end else begin
        clear_id = 1'b1;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else       count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc_i;
      inst_mem[wr_ptr] <= fetch_inst_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      id_valid_o <= 1'b0;
      id_pc_o    <= '0;
      id_inst_o  <= NOP;
      ovf_o      <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf_o <= ovf_nxt;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        id_valid_o <= 1'b0;
        id_inst_o  <= NOP;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (load_head) begin
          id_valid_o <= 1'b1;
          id_pc_o    <= pc_mem[rd_ptr];
          id_inst_o  <= inst_mem[rd_ptr];
        end else if (load_fetch) begin
          id_valid_o <= 1'b1;
          id_pc_o    <= fetch_pc_i;
          id_inst_o  <= fetch_inst_i;
        end else if (clear_id) begin
          id_valid_o <= 1'b0;
          id_inst_o  <= NOP;
        end
      end
    end
  end

endmodule
